// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: 9-entry search buffer, 8-entry look-ahead, codewords (pos, len, next char).
// Define LZ77_ENC_EARLY_EXIT_EN to end SEARCH as soon as the longest possible match is found.
module lz77_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       valid,
  output logic [3:0] code_pos,
  output logic [2:0] code_len,
  output logic [7:0] char_nxt,
  output logic       encode,
  output logic       finish
);

  localparam logic [7:0] TERM_CHAR = 8'h24;

  // state    | meaning
  // S_FILL   | accept characters until look-ahead full or terminator stored
  // S_SEARCH | score one search position per cycle, keep the best
  // S_EMIT   | codeword on the outputs with valid high
  // S_SHIFT  | move len+1 characters from look-ahead into search buffer
  // S_DONE   | terminator emitted, idle until reset
  typedef enum logic [2:0] {S_FILL, S_SEARCH, S_EMIT, S_SHIFT, S_DONE} state_t;

  state_t     state, state_nxt;

  logic [7:0] sb [9];
  logic [7:0] la [8];
  logic [3:0] la_cnt;
  logic [3:0] sb_cnt;
  logic       term;
  logic [3:0] p_idx;
  logic [2:0] best_len;
  logic [3:0] best_pos;
  logic [2:0] sh_left;

  logic [7:0] win [17];
  logic [2:0] max_len;
  logic [2:0] cand_len;
  logic [2:0] sel_len;
  logic [3:0] sel_pos;
  logic       take;
  logic       run;
  logic [4:0] idx;
  logic       search_last;

  always_comb begin
    if (la_cnt == 4'd0)      max_len = 3'd0;
    else if (la_cnt >= 4'd8) max_len = 3'd7;
    else                     max_len = 3'(la_cnt - 4'd1);
  end

  // Oldest search entry first, then look-ahead: window index j lives at win[j+9].
  always_comb begin
    for (int i = 0; i < 9; i++) win[i] = sb[8 - i];
    for (int m = 0; m < 8; m++) win[9 + m] = la[m];
  end

  always_comb begin
    cand_len = 3'd0;
    idx      = 5'd0;
    run      = (p_idx < sb_cnt);
    for (int k = 0; k < 7; k++) begin
      idx = 5'(8 + k) - {1'b0, p_idx};
      if (run && (3'(k) < max_len) && (win[idx] == la[k])) cand_len = 3'(k + 1);
      else run = 1'b0;
    end
  end

  assign take    = (cand_len > best_len);
  assign sel_len = take ? cand_len : best_len;
  assign sel_pos = take ? p_idx : best_pos;

`ifdef LZ77_ENC_EARLY_EXIT_EN
  assign search_last = (p_idx == 4'd8) || (sel_len == max_len);
`else
  assign search_last = (p_idx == 4'd8);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = encode && (la_cnt < 4'd8) && !term;
        if ((la_cnt == 4'd8) || term) state_nxt = S_SEARCH;
      end
      S_SEARCH: if (search_last) state_nxt = S_EMIT;
      S_EMIT:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (sh_left == 3'd0) begin
          if (char_nxt == TERM_CHAR) state_nxt = S_DONE;
          else if (term)             state_nxt = S_SEARCH;
          else                       state_nxt = S_FILL;
        end
      end
      S_DONE:   state_nxt = S_DONE;
      default:  state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) sb[i] <= 8'd0;
      for (int m = 0; m < 8; m++) la[m] <= 8'd0;
      la_cnt   <= 4'd0;
      sb_cnt   <= 4'd0;
      term     <= 1'b0;
      p_idx    <= 4'd0;
      best_len <= 3'd0;
      best_pos <= 4'd0;
      sh_left  <= 3'd0;
      valid    <= 1'b0;
      code_pos <= 4'd0;
      code_len <= 3'd0;
      char_nxt <= 8'd0;
      encode   <= 1'b0;
      finish   <= 1'b0;
    end else begin
      valid  <= 1'b0;
      encode <= (state_nxt != S_DONE);
      finish <= (state_nxt == S_DONE);
      case (state)
        S_FILL: begin
          if (in_valid && in_ready) begin
            la[la_cnt[2:0]] <= chardata;
            la_cnt          <= la_cnt + 4'd1;
            if (chardata == TERM_CHAR) term <= 1'b1;
          end
        end
        S_SEARCH: begin
          p_idx    <= p_idx + 4'd1;
          best_len <= sel_len;
          best_pos <= sel_pos;
          if (search_last) begin
            valid    <= 1'b1;
            code_len <= sel_len;
            code_pos <= sel_pos;
            char_nxt <= la[sel_len];
            sh_left  <= sel_len;
          end
        end
        S_SHIFT: begin
          sb[0] <= la[0];
          for (int i = 1; i < 9; i++) sb[i] <= sb[i - 1];
          for (int m = 0; m < 7; m++) la[m] <= la[m + 1];
          la[7]   <= 8'd0;
          la_cnt  <= la_cnt - 4'd1;
          if (sb_cnt < 4'd9) sb_cnt <= sb_cnt + 4'd1;
          sh_left <= sh_left - 3'd1;
        end
        default: ;
      endcase
      // Fresh scan on every entry into SEARCH, whether from FILL or SHIFT.
      if ((state != S_SEARCH) && (state_nxt == S_SEARCH)) begin
        p_idx    <= 4'd0;
        best_len <= 3'd0;
        best_pos <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_lz77_encoder.sv
// Bench for lz77_encoder: directed vector table plus random streams against a stream-level reference.
module tb_lz77_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] chardata = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       valid;
  logic [3:0] code_pos;
  logic [2:0] code_len;
  logic [7:0] char_nxt;
  logic       encode;
  logic       finish;

  lz77_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .chardata (chardata),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .valid    (valid),
    .code_pos (code_pos),
    .code_len (code_len),
    .char_nxt (char_nxt),
    .encode   (encode),
    .finish   (finish)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]        n;
    logic [15:0][7:0]  s;
    logic [3:0]        ncw;
    logic [15:0][14:0] cw;
    logic              chk;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] stim_q [$];
  logic [14:0] exp_q [$];
  logic [14:0] got_q [$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] ch(input byte c);
    if (c == "$") return 8'h24;
    if (c >= "0" && c <= "9") return 8'(c - "0");
    return 8'(c - "a" + 10);
  endfunction

  function automatic vec_t mk(input string t, input logic chk);
    vec_t v;
    v = '0;
    v.n = 5'(t.len());
    for (int i = 0; i < t.len(); i++) v.s[i] = ch(t[i]);
    v.chk = chk;
    return v;
  endfunction

  function automatic vec_t add(input vec_t v, input int p, input int l, input logic [7:0] c);
    vec_t r;
    r = v;
    r.cw[r.ncw] = {4'(p), 3'(l), c};
    r.ncw = r.ncw + 4'd1;
    return r;
  endfunction

  // Stream-level model: look-ahead is the next min(8, remaining) characters,
  // history is whatever has already been coded (at most 9 back).
  function automatic void ref_encode();
    int i, n, lac, mx, bl, bp, l;
    exp_q.delete();
    n = stim_q.size();
    i = 0;
    while (i < n) begin
      lac = (n - i < 8) ? n - i : 8;
      mx  = (lac - 1 < 7) ? lac - 1 : 7;
      bl  = 0;
      bp  = 0;
      for (int p = 0; p <= 8 && p < i; p++) begin
        l = 0;
        while (l < mx && stim_q[i - p - 1 + l] == stim_q[i + l]) l++;
        if (l > bl) begin
          bl = l;
          bp = p;
        end
      end
      exp_q.push_back({4'(bp), 3'(bl), stim_q[i + bl]});
      i += bl + 1;
    end
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    chardata = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_outs", int'({in_ready, valid, code_pos, code_len, char_nxt, encode, finish}), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("encode_pre", int'(encode), 0);
    @(negedge clk);
    check("encode_rise", int'(encode), 1);
  endtask

  // mode 0: gap-free, 1: random in_valid gaps, 2: in_valid always high (junk after the stream)
  task automatic run_stream(input int mode, input logic chk, input logic rst);
    int idx, n, cyc, junk, acc8, pend_cyc, pend_len;
    logic pend, prev_valid, first_seen;
    got_q.delete();
    n = stim_q.size();
    idx = 0; cyc = 0; junk = 0; acc8 = -1;
    pend = 1'b0; prev_valid = 1'b0; first_seen = 1'b0;
    pend_cyc = 0; pend_len = 0;
    if (rst) do_reset();
    while (!finish && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        got_q.push_back({code_pos, code_len, char_nxt});
        check("valid_pulse", int'(prev_valid), 0);
`ifndef LZ77_ENC_EARLY_EXIT_EN
        if (chk && mode == 0 && !first_seen && acc8 >= 0)
          check("search_lat", cyc - (acc8 + 1), 10);
`endif
        first_seen = 1'b1;
        pend = 1'b1;
        pend_cyc = cyc;
        pend_len = int'(code_len);
      end else if (pend && in_ready) begin
        check("ready_gap", cyc - pend_cyc, pend_len + 2);
        pend = 1'b0;
      end
      prev_valid = valid;
      if (chk && mode == 0 && acc8 >= 0 && cyc == acc8 + 1)
        check("ready_full", int'(in_ready), 0);
      if (mode == 2)      in_valid = 1'b1;
      else if (mode == 1) in_valid = (idx < n) && ($urandom_range(0, 2) != 0);
      else                in_valid = (idx < n);
      chardata = (idx < n) ? stim_q[idx] : 8'h0f;
      if (in_valid && in_ready) begin
        if (idx < n) begin
          idx++;
          if (idx == 8) acc8 = cyc;
        end else begin
          junk++;
        end
      end
    end
    in_valid = 1'b0;
    check("finish", int'(finish), 1);
    check("encode_done", int'(encode), 0);
    check("accepted", idx, n);
    check("junk_acc", junk, 0);
    check("cw_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check("codeword", int'(got_q[k]), int'(exp_q[k]));
  endtask

  initial begin
    int len, rng, idx;
    vecs[0] = add(add(mk("0000$", 1'b0), 0, 0, 8'h00), 0, 3, 8'h24);
    vecs[1] = add(add(add(add(mk("123$", 1'b0), 0, 0, 8'h01), 0, 0, 8'h02), 0, 0, 8'h03), 0, 0, 8'h24);
    vecs[2] = add(add(add(mk("121212$", 1'b0), 0, 0, 8'h01), 0, 0, 8'h02), 1, 4, 8'h24);
    vecs[3] = add(add(add(mk("555555555555$", 1'b1), 0, 0, 8'h05), 0, 7, 8'h05), 0, 3, 8'h24);
    vecs[4] = add(mk("$", 1'b0), 0, 0, 8'h24);
    vecs[5] = mk("0123456780$", 1'b0);
    for (int d = 0; d < 9; d++) vecs[5] = add(vecs[5], 0, 0, 8'(d));
    vecs[5] = add(vecs[5], 8, 1, 8'h24);
    vecs[6] = mk("01234567890$", 1'b0);
    for (int d = 0; d < 10; d++) vecs[6] = add(vecs[6], 0, 0, 8'(d));
    vecs[6] = add(add(vecs[6], 0, 0, 8'h00), 0, 0, 8'h24);

    for (int mode = 0; mode < 3; mode++) begin
      for (int v = 0; v < 7; v++) begin
        stim_q.delete();
        exp_q.delete();
        for (int i = 0; i < int'(vecs[v].n); i++) stim_q.push_back(vecs[v].s[i]);
        for (int i = 0; i < int'(vecs[v].ncw); i++) exp_q.push_back(vecs[v].cw[i]);
        run_stream(mode, vecs[v].chk, 1'b1);
      end
    end

    // Reset while SEARCH is running, then replay the same stream without a fresh reset.
    stim_q.delete();
    stim_q.push_back(8'h01); stim_q.push_back(8'h02);
    stim_q.push_back(8'h03); stim_q.push_back(8'h24);
    ref_encode();
    do_reset();
    idx = 0;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      chardata = stim_q[idx];
      if (in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_encode", int'(encode), 1);
    check("pre_reset_ready", int'(in_ready), 0);
    #2 reset = 1'b0;
    #1 check("reset_mid", int'({in_ready, valid, code_pos, code_len, char_nxt, encode, finish}), 0);
    @(negedge clk);
    reset = 1'b1;
    run_stream(0, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(0, 30);
      rng = $urandom_range(1, 15);
      stim_q.delete();
      for (int k = 0; k < len; k++) stim_q.push_back(8'($urandom_range(0, rng)));
      stim_q.push_back(8'h24);
      ref_encode();
      run_stream(t % 3, 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lz77_encoder.md
# lz77_encoder

Streaming LZ77 encoder and the transmit-side counterpart of `LZ77_Decoder`. It accepts a character stream (hex digits 0x00–0x0F, terminated by `$` = 0x24) and emits `(code_pos, code_len, char_nxt)` codewords in the exact format the decoder consumes. It uses a 9-entry search buffer and an 8-entry look-ahead buffer, and sits upstream of the decoder in the compression datapath.

## Interface
- No parameters. Geometry is fixed: search buffer 9, look-ahead 8, maximum match length 7.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `chardata`  in  8  input character.
- `in_valid`  in  1  `chardata` is valid this cycle.
- `in_ready`  out  1  encoder accepts `chardata`; a transfer occurs when `in_valid & in_ready`.
- `valid`  out  1  codeword outputs are valid; one-cycle pulse, no backpressure.
- `code_pos`  out  4  match start, 0..8; 0 = most recently emitted character.
- `code_len`  out  3  match length, 0..7.
- `char_nxt`  out  8  literal that follows the match.
- `encode`  out  1  high while the encoder is active.
- `finish`  out  1  high after the final codeword; sticky until reset.

## Operation
- **Buffers.**
  - `SB[0..8]`: `SB[0]` is the newest character. An entry is valid only after it has been filled; invalid entries never match.
  - `LA[0..7]` plus `la_cnt` (0..8) and a `term` flag, set when 0x24 is stored.
- **States:** `FILL` → `SEARCH` → `EMIT` → `SHIFT` → `FILL` or `DONE`.
- **FILL.**
  - `in_ready = (la_cnt < 8) & !term`.
  - Each transfer appends to `LA[la_cnt]`.
  - Exit to `SEARCH` when `la_cnt == 8` or `term` is set.
- **Virtual window.** Index −(p+1) maps to `SB[p]`; index ≥ 0 maps to `LA`.
- **Candidate length at `p`.** Length is the largest `L ≤ min(7, la_cnt−1)` such that for every `k < L`, window[−(p+1)+k] == `LA[k]`.
  - Overlap into `LA` is allowed.
  - Compare all 8 bits.
  - A candidate at an invalid `SB[p]` has length 0.
- **SEARCH.** Evaluates `p = 0..8`, one candidate per cycle, keeping the best.
  - Selection: longest `L` wins; on a tie, the smaller `p` wins (the first one found).
  - If the best `L == 0`, then `code_pos = 0`.
- **EMIT.** Drive the registered codeword with `valid = 1` for exactly one cycle; `char_nxt = LA[L]`.
- **SHIFT.** Runs L+1 cycles. Each cycle shifts `LA[0]` into `SB[0]` (SB ages by one, `SB[8]` drops), shifts `LA` down, and decrements `la_cnt`.
- **After SHIFT.**
  - If the emitted `char_nxt == 0x24`, go to `DONE`.
  - Otherwise go to `FILL`; if `term` is set, go directly to `SEARCH` instead.
- **DONE.** `finish = 1`, `encode = 0`, `in_ready = 0`, `valid = 0`; the block holds here until reset.

## Timing
- **Reset values.** All outputs are 0 (`in_ready`, `valid`, `code_pos`, `code_len`, `char_nxt`, `encode`, `finish`). Buffers are cleared, `la_cnt = 0`, state = `FILL`.
- **encode.** Rises on the first clock after `reset` deasserts and stays high until `DONE`.
- **SEARCH duration.** Exactly 9 cycles; `valid` asserts in the following cycle.
- **Latency.** `FILL` exit to `valid` is 10 cycles. `valid` to `in_ready` re-asserting is L+2 cycles (1 cycle to leave `EMIT`, L+1 `SHIFT` cycles).
- **in_ready.** Low in `SEARCH`, `EMIT`, `SHIFT` and `DONE`. `in_valid` while `in_ready` is low is ignored, and no data is lost.
- **After termination.** Characters offered after 0x24 are never accepted.
- **Reset mid-operation.** Any state returns immediately to the reset values. A partially emitted stream is abandoned.
- **Empty search buffer** on the first codeword always yields `(0, 0, LA[0])`.

## Configuration
- **Macro:** `LZ77_ENC_EARLY_EXIT_EN`.
- **Defined:** `SEARCH` ends in the cycle its best `L` reaches `min(7, la_cnt−1)`, and `EMIT` follows next. Codewords are identical to the undefined case, because candidates are scanned in ascending `p`; only latency shrinks.
- **Undefined:** `SEARCH` always takes 9 cycles.

## Test plan
- **Overlap match:** input 0,0,0,0,0x24 → codewords (0,0,0x00), then (0,3,0x24); `finish` = 1 after the second codeword.
- **No matches:** input 1,2,3,0x24 → (0,0,1), (0,0,2), (0,0,3), (0,0,0x24).
- **Overlapping match at p = 1:** input 1,2,1,2,1,2,0x24 → (0,0,1), (0,0,2), (1,4,0x24).
- **Full look-ahead:** 12 × 0x05, then 0x24 → (0,0,5), (0,7,5), (0,3,0x24). Check `in_ready` drops when `la_cnt` = 8 and `valid` is exactly 10 cycles after `SEARCH` entry (macro undefined).
- **Backpressure:** random `in_valid` gaps, and `in_valid` held high through `SEARCH`/`SHIFT` → same codewords as the gap-free run, with no duplicated or dropped characters.
- **Reset mid-SEARCH:** assert `reset` low → all outputs are 0 within the same cycle; re-running stream 2 reproduces its codewords exactly.
